instr_mem_loader: RTL and testbench

- Writer-side counterpart of the byte-addressed, big-endian instruction memory (256 bytes).
- Accepts a stream of 32-bit instruction words over a valid/ready handshake.
- Serialises each word into four byte writes on the memory's byte write port, most significant byte at the lowest address.
- Sits between the boot/programming source (testbench or host link) and the instruction memory, replacing hard-coded reset-time contents.

---
 rtl/instr_mem_loader_if.sv | 22 ++
 rtl/instr_mem_loader.sv | 129 ++++++++++++
 tb/tb_instr_mem_loader.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/instr_mem_loader_if.sv
// Word-stream handshake and byte-write port bundle for the instruction memory loader.
interface instr_mem_loader_if #(
  parameter int ADDR_W = 32
);
  logic              word_valid;
  logic              word_ready;
  logic [31:0]       word_data;
  logic              word_last;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;

  modport master (
    output word_valid, word_data, word_last,
    input  word_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  word_valid, word_data, word_last,
    output word_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/instr_mem_loader.sv
// Serialises 32-bit words into big-endian byte writes: handshake at edge N, bytes in N+1..N+4.
// Source is stalled (word_ready low) while writing; an overflowing word is refused and the session ends in ERR.
module instr_mem_loader #(
  parameter int                DEPTH     = 256,
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  instr_mem_loader_if.slave        bus,
  output logic                     busy,
  output logic                     done,
  output logic                     error,
  output logic [7:0]               word_count
);

  typedef enum logic [2:0] {IDLE, LOAD, WRITE, DONE, ERR} state_t;

  localparam logic [ADDR_W-1:0] FULL_LIM = ADDR_W'(DEPTH - 4);

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] pointer;
  logic [1:0]        byte_idx;
  logic [31:0]       word_q;
  logic              last_q;
  logic              full;
  logic              accept;
  logic [7:0]        word_byte;

  assign full   = (pointer > FULL_LIM);
  assign accept = (state == LOAD) && !full && bus.word_valid;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE, ERR: begin
        if (start) state_nxt = LOAD;
      end
      LOAD: begin
        if (full)        state_nxt = ERR;
        else if (accept) state_nxt = WRITE;
      end
      WRITE: begin
        if (byte_idx == 2'd3) state_nxt = last_q ? DONE : LOAD;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pointer    <= BASE_ADDR;
      byte_idx   <= 2'd0;
      word_q     <= 32'd0;
      last_q     <= 1'b0;
      word_count <= 8'd0;
    end else begin
      case (state)
        IDLE, DONE, ERR: begin
          if (start) begin
            pointer    <= BASE_ADDR;
            word_count <= 8'd0;
          end
        end
        LOAD: begin
          if (accept) begin
            word_q   <= bus.word_data;
            last_q   <= bus.word_last;
            byte_idx <= 2'd0;
          end
        end
        WRITE: begin
          pointer  <= pointer + ADDR_W'(1);
          byte_idx <= byte_idx + 2'd1;
          // count only completed words, saturating so a long session cannot wrap
          if (byte_idx == 2'd3 && word_count != 8'hFF) begin
            word_count <= word_count + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    case (byte_idx)
      2'd0:    word_byte = word_q[31:24];
      2'd1:    word_byte = word_q[23:16];
      2'd2:    word_byte = word_q[15:8];
      default: word_byte = word_q[7:0];
    endcase
  end

  always_comb begin
    bus.word_ready = 1'b0;
    bus.mem_we     = 1'b0;
    bus.mem_addr   = '0;
    bus.mem_wdata  = 8'd0;
    busy           = 1'b0;
    done           = 1'b0;
    error          = 1'b0;
    case (state)
      LOAD: begin
        busy           = 1'b1;
        bus.word_ready = !full;
      end
      WRITE: begin
        busy          = 1'b1;
        bus.mem_we    = 1'b1;
        bus.mem_addr  = pointer;
        bus.mem_wdata = word_byte;
      end
      DONE:    done  = 1'b1;
      ERR:     error = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_instr_mem_loader.sv
// Directed bench for instr_mem_loader: table of word vectors plus overflow and reset sequences.
module tb_instr_mem_loader;

  logic       clk;
  logic       rst;
  logic       start;
  logic       busy;
  logic       done;
  logic       error;
  logic [7:0] word_count;

  instr_mem_loader_if #(.ADDR_W(32)) bus ();

  instr_mem_loader #(.DEPTH(256), .ADDR_W(32), .BASE_ADDR(32'd0)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .bus        (bus),
    .busy       (busy),
    .done       (done),
    .error      (error),
    .word_count (word_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        start;
    logic [31:0] word;
    logic        last;
    int          gap;
    logic        poke;
    logic [31:0] exp_addr;
    logic [31:0] exp_bytes;
    logic [7:0]  exp_count;
  } vec_t;

  vec_t vecs [6];
  int   n_vec  = 0;
  int   n_miss = 0;

  // write monitor: mirrors every byte write into a shadow memory
  logic [7:0] shadow [0:255];
  int         wr_cnt   = 0;
  int         bad_addr = 0;

  always @(negedge clk) begin
    if (bus.mem_we) begin
      wr_cnt = wr_cnt + 1;
      if (bus.mem_addr > 32'd255) bad_addr = bad_addr + 1;
      else shadow[bus.mem_addr[7:0]] = bus.mem_wdata;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    bus.word_valid = 1'b0;
    chk("start_busy",  32'(busy), 32'd1);
    chk("start_done",  32'(done), 32'd0);
    chk("start_error", 32'(error), 32'd0);
    chk("start_count", 32'(word_count), 32'd0);
    chk("start_rdy",   32'(bus.word_ready), 32'd1);
  endtask

  task automatic send_word(input logic [31:0] w, input logic l, input logic [31:0] ea,
                           input logic [31:0] eb, input logic [7:0] ec, input logic er,
                           input logic poke);
    int n;
    bus.word_data  = w;
    bus.word_last  = l;
    bus.word_valid = 1'b1;
    n = 0;
    while (bus.word_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("handshake", 32'(bus.word_ready), 32'd1);
    @(negedge clk);
    if (l) bus.word_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("wr_we",    32'(bus.mem_we), 32'd1);
      chk("wr_addr",  bus.mem_addr, ea + 32'(i));
      chk("wr_data",  32'(bus.mem_wdata), 32'(eb[31-8*i -: 8]));
      chk("wr_rdy",   32'(bus.word_ready), 32'd0);
      start = poke && (i == 1);
      @(negedge clk);
    end
    start = 1'b0;
    chk("post_we",    32'(bus.mem_we), 32'd0);
    chk("post_rdy",   32'(bus.word_ready), 32'(er));
    chk("post_done",  32'(done), 32'(l));
    chk("post_busy",  32'(busy), 32'(!l));
    chk("post_count", 32'(word_count), 32'(ec));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int snap;
    int bad;
    logic [31:0] w;

    rst = 1'b0;
    start = 1'b0;
    bus.word_valid = 1'b0;
    bus.word_data  = 32'd0;
    bus.word_last  = 1'b0;

    vecs[0] = '{1'b1, 32'hE3A00014, 1'b1, 0, 1'b0, 32'd0, {8'hE3, 8'hA0, 8'h00, 8'h14}, 8'd1};
    vecs[1] = '{1'b1, 32'hE0000000, 1'b0, 0, 1'b0, 32'd0, {8'hE0, 8'h00, 8'h00, 8'h00}, 8'd1};
    vecs[2] = '{1'b0, 32'hE3A01A01, 1'b0, 0, 1'b1, 32'd4, {8'hE3, 8'hA0, 8'h1A, 8'h01}, 8'd2};
    vecs[3] = '{1'b0, 32'hE3A02103, 1'b1, 0, 1'b0, 32'd8, {8'hE3, 8'hA0, 8'h21, 8'h03}, 8'd3};
    vecs[4] = '{1'b1, 32'h12345678, 1'b0, 0, 1'b0, 32'd0, {8'h12, 8'h34, 8'h56, 8'h78}, 8'd1};
    vecs[5] = '{1'b0, 32'h9ABCDEF0, 1'b1, 7, 1'b1, 32'd4, {8'h9A, 8'hBC, 8'hDE, 8'hF0}, 8'd2};

    #1;
    chk("rst_rdy",   32'(bus.word_ready), 32'd0);
    chk("rst_we",    32'(bus.mem_we), 32'd0);
    chk("rst_addr",  bus.mem_addr, 32'd0);
    chk("rst_wdata", 32'(bus.mem_wdata), 32'd0);
    chk("rst_busy",  32'(busy), 32'd0);
    chk("rst_done",  32'(done), 32'd0);
    chk("rst_error", 32'(error), 32'd0);
    chk("rst_count", 32'(word_count), 32'd0);

    @(negedge clk);
    rst = 1'b1;
    bus.word_valid = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("idle_rdy",  32'(bus.word_ready), 32'd0);
    chk("idle_we",   32'(bus.mem_we), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);

    for (int v = 0; v < 6; v++) begin
      if (vecs[v].start) do_start();
      for (int g = 0; g < vecs[v].gap; g++) begin
        bus.word_valid = 1'b0;
        start = vecs[v].poke && (g == 3);
        chk("gap_we",  32'(bus.mem_we), 32'd0);
        chk("gap_rdy", 32'(bus.word_ready), 32'd1);
        @(negedge clk);
      end
      start = 1'b0;
      send_word(vecs[v].word, vecs[v].last, vecs[v].exp_addr, vecs[v].exp_bytes,
                vecs[v].exp_count, !vecs[v].last, vecs[v].poke);
    end

    // overflow: 64 words fill bytes 0..255, the 65th must be refused
    snap = wr_cnt;
    do_start();
    for (int i = 0; i < 64; i++) begin
      w = {8'(4*i), 8'(4*i+1), 8'(4*i+2), 8'(4*i+3)};
      send_word(w, 1'b0, 32'(4*i), w, 8'(i+1), i != 63, 1'b0);
    end
    bus.word_data  = 32'hDEADBEEF;
    bus.word_valid = 1'b1;
    chk("ovf_rdy",  32'(bus.word_ready), 32'd0);
    chk("ovf_busy", 32'(busy), 32'd1);
    @(negedge clk);
    chk("ovf_error", 32'(error), 32'd1);
    chk("ovf_done",  32'(done), 32'd0);
    chk("ovf_busy2", 32'(busy), 32'd0);
    chk("ovf_count", 32'(word_count), 32'd64);
    repeat (3) begin
      chk("ovf_rdy2", 32'(bus.word_ready), 32'd0);
      chk("ovf_we",   32'(bus.mem_we), 32'd0);
      @(negedge clk);
    end
    chk("ovf_writes", 32'(wr_cnt - snap), 32'd256);
    chk("ovf_badaddr", 32'(bad_addr), 32'd0);
    bad = 0;
    for (int a = 0; a < 256; a++) if (shadow[a] !== 8'(a)) bad++;
    chk("ovf_image", 32'(bad), 32'd0);

    // reset asserted during the second byte of the first word
    snap = wr_cnt;
    do_start();
    bus.word_data  = 32'h11223344;
    bus.word_last  = 1'b0;
    bus.word_valid = 1'b1;
    @(negedge clk);
    chk("mid_addr0", bus.mem_addr, 32'd0);
    @(negedge clk);
    chk("mid_addr1", bus.mem_addr, 32'd1);
    chk("mid_data1", 32'(bus.mem_wdata), 32'h22);
    #2;
    rst = 1'b0;
    #1;
    chk("mid_we",    32'(bus.mem_we), 32'd0);
    chk("mid_addr",  bus.mem_addr, 32'd0);
    chk("mid_wdata", 32'(bus.mem_wdata), 32'd0);
    chk("mid_busy",  32'(busy), 32'd0);
    chk("mid_rdy",   32'(bus.word_ready), 32'd0);
    chk("mid_error", 32'(error), 32'd0);
    chk("mid_count", 32'(word_count), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("mid_rdy_idle", 32'(bus.word_ready), 32'd0);
    chk("mid_writes",   32'(wr_cnt - snap), 32'd2);
    chk("mid_byte2",    32'(shadow[2]), 32'h02);
    chk("mid_byte3",    32'(shadow[3]), 32'h03);

    do_start();
    send_word(32'h55667788, 1'b1, 32'd0, {8'h55, 8'h66, 8'h77, 8'h88}, 8'd1, 1'b0, 1'b0);
    chk("re_byte0", 32'(shadow[0]), 32'h55);
    chk("re_byte3", 32'(shadow[3]), 32'h88);
    chk("re_writes", 32'(wr_cnt - snap), 32'd6);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
